// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Optional build macro used by this slice: JK_TOGGLE_MODE_EN.
package jk_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        ERROR = 2'd3
    } jk_state_e;

    // 2-bit excitation codes, packed as {J, K}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: maps (current Q, target Q) to (J, K).
// Build macro: JK_TOGGLE_MODE_EN resolves don't-cares so changing bits toggle;
// without it, don't-cares resolve to 0 and J=K=1 is never produced.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q_cur,
    input  logic q_tgt,
    output logic j,
    output logic k
);

    logic [1:0] code;

    // Select the excitation code for one bit; unchanged bits always hold.
    always_comb begin
        code = JK_HOLD;
        if (q_cur != q_tgt) begin
`ifdef JK_TOGGLE_MODE_EN
            code = JK_TOGGLE;
`else
            code = q_tgt ? JK_SET : JK_RESET;
`endif
        end
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of W JK flip-flops toward a requested target word, verifies
// the bank's Q one cycle after each excitation pulse, retries on mismatch and
// raises a sticky error once retries are exhausted.
// Build macro: JK_TOGGLE_MODE_EN (selects toggle excitation in jk_excite_bit).
//
// Handshake: a target word transfers on a rising clk edge where tgt_valid and
// tgt_ready are both 1. tgt_ready is registered and depends only on internal
// state; the producer must hold tgt_data stable while tgt_valid is high and
// tgt_ready is low.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [W-1:0]     tgt_data,
    output logic [W-1:0]     j_out,
    output logic [W-1:0]     k_out,
    input  logic [W-1:0]     q_in,
    output logic             done,
    output logic             err,
    input  logic             err_clear,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    jk_state_e         state_q, state_d;
    logic [W-1:0]      tgt_q, tgt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [W-1:0]      j_d, k_d;
    logic              ready_d, done_d, err_d;
    logic [CNT_W-1:0]  cnt_d, cnt_inc;
    logic [W-1:0]      exc_tgt, exc_j, exc_k;

    // On accept the excitation targets the incoming word; on retry it
    // targets the latched word. Both use q_in sampled at the same edge.
    assign exc_tgt = (state_q == IDLE) ? tgt_data : tgt_q;

    // Saturating increment for the mismatch counter.
    assign cnt_inc = (&mismatch_cnt) ? mismatch_cnt : mismatch_cnt + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            jk_excite_bit u_bit (
                .q_cur (q_in[gi]),
                .q_tgt (exc_tgt[gi]),
                .j     (exc_j[gi]),
                .k     (exc_k[gi])
            );
        end
    endgenerate

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err;
        cnt_d   = mismatch_cnt;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (tgt_valid && tgt_ready) begin
                    tgt_d   = tgt_data;
                    retry_d = '0;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    ready_d = 1'b0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Bank captures the excitation at this edge; pulse ends.
                state_d = CHECK;
            end
            CHECK: begin
                if (q_in == tgt_q) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        j_d     = exc_j;
                        k_d     = exc_k;
                        state_d = DRIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                if (err_clear) begin
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the bank drive low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tgt_q        <= '0;
            retry_q      <= '0;
            j_out        <= '0;
            k_out        <= '0;
            tgt_ready    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            retry_q      <= retry_d;
            j_out        <= j_d;
            k_out        <= k_d;
            tgt_ready    <= ready_d;
            done         <= done_d;
            err          <= err_d;
            mismatch_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank model.
// Build macro honoured: JK_TOGGLE_MODE_EN (changes expected J/K values only).
module tb_jk_excitation_driver;

    localparam int W         = 8;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             tgt_valid = 1'b0;
    logic             tgt_ready;
    logic [W-1:0]     tgt_data  = '0;
    logic [W-1:0]     j_out, k_out, q_in;
    logic             done, err;
    logic             err_clear = 1'b0;
    logic [CNT_W-1:0] mismatch_cnt;

    jk_excitation_driver #(.W(W), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tgt_valid    (tgt_valid),
        .tgt_ready    (tgt_ready),
        .tgt_data     (tgt_data),
        .j_out        (j_out),
        .k_out        (k_out),
        .q_in         (q_in),
        .done         (done),
        .err          (err),
        .err_clear    (err_clear),
        .mismatch_cnt (mismatch_cnt)
    );

    // ---------------- JK bank model ----------------
    // Q+ = J & ~Q | ~K & Q ; load overrides, ignore freezes, stuck0 pins bits low.
    logic [W-1:0] bank_q   = '0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] stuck0   = '0;
    logic         load_en  = 1'b0;
    logic         ignore   = 1'b0;

    always @(posedge clk) begin
        if (load_en)      bank_q <= load_val & ~stuck0;
        else if (!ignore) bank_q <= ((j_out & ~bank_q) | (~k_out & bank_q)) & ~stuck0;
    end
    assign q_in = bank_q;

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Expected excitation for a (current Q, target) pair, from the JK table.
    function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_TOGGLE_MODE_EN
        return {q ^ t, q ^ t};
`else
        return {t & ~q, q & ~t};
`endif
    endfunction

    // On every done pulse the bank must hold the oldest outstanding target.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'(done), 32'(0));
            end else begin
                exp_v = exp_q.pop_front();
                check("done_bank_q", 32'(q_in), 32'(exp_v));
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input logic [W-1:0] d);
        int t = 0;
        while (!tgt_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(tgt_ready), 32'(1));
        tgt_valid = 1'b1;
        tgt_data  = d;
        exp_q.push_back(d);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        check("done_seen", 32'(done), 32'(1));
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Returns the number of cycles with a non-zero J drive before err rises.
    task automatic wait_err(output int drives);
        int t = 0;
        drives = (j_out != '0) ? 1 : 0;
        while (!err && t < 40) begin
            @(negedge clk);
            t++;
            if (j_out != '0) drives++;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int n, drives, exp_cnt;
    logic [2*W-1:0] jk;

    initial begin
        // Reset held for 2 cycles; all outputs low.
        rst_n = 1'b0;
        load_en = 1'b1;
        load_val = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(tgt_ready), 32'(0));
        check("rst_j", 32'(j_out), 32'(0));
        check("rst_k", 32'(k_out), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_cnt", 32'(mismatch_cnt), 32'(0));
        rst_n = 1'b1;
        load_en = 1'b0;
        #1 check("ready_at_release", 32'(tgt_ready), 32'(0));
        @(negedge clk);
        check("ready_first_edge", 32'(tgt_ready), 32'(1));
        exp_cnt = 0;

        // Normal set: 0x00 -> 0xA5.
        send(8'hA5);
        jk = exp_jk(8'h00, 8'hA5);
        check("set_j", 32'(j_out), 32'(jk[2*W-1:W]));
        check("set_k", 32'(k_out), 32'(jk[W-1:0]));
        check("set_ready_low", 32'(tgt_ready), 32'(0));
        wait_done(n);
        check("set_latency", 32'(n + 1), 32'(3));
        check("set_cnt", 32'(mismatch_cnt), 32'(0));
        check("set_ready_done", 32'(tgt_ready), 32'(1));

        // Clear path: 0xFF -> 0x0F.
        load_bank(8'hFF);
        send(8'h0F);
        jk = exp_jk(8'hFF, 8'h0F);
        check("clr_j", 32'(j_out), 32'(jk[2*W-1:W]));
        check("clr_k", 32'(k_out), 32'(jk[W-1:0]));
        wait_done(n);
        check("clr_latency", 32'(n + 1), 32'(3));

        // Back-to-back accept on the done cycle; target equals current Q.
        send(8'h0F);
        check("same_j", 32'(j_out), 32'(0));
        check("same_k", 32'(k_out), 32'(0));
        wait_done(n);
        check("same_latency", 32'(n + 1), 32'(3));

        // Single fault: bank ignores the first excitation pulse.
        ignore = 1'b1;
        send(8'h3C);
        jk = exp_jk(8'h0F, 8'h3C);
        check("fault_j1", 32'(j_out), 32'(jk[2*W-1:W]));
        check("fault_k1", 32'(k_out), 32'(jk[W-1:0]));
        @(negedge clk);
        ignore = 1'b0;
        check("fault_check_jk", 32'({j_out, k_out}), 32'(0));
        @(negedge clk);
        exp_cnt = 1;
        check("fault_j2", 32'(j_out), 32'(jk[2*W-1:W]));
        check("fault_k2", 32'(k_out), 32'(jk[W-1:0]));
        check("fault_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
        wait_done(n);
        check("fault_latency", 32'(n + 3), 32'(5));
        check("fault_err", 32'(err), 32'(0));

        // Stuck bit 0 at 0, target 0x01: three drives then error.
        load_bank(8'h00);
        stuck0 = 8'h01;
        send(8'h01);
        wait_err(drives);
        exp_q.delete();
        exp_cnt = exp_cnt + 3;
        check("stuck_drives", 32'(drives), 32'(MAX_RETRY + 1));
        check("stuck_err", 32'(err), 32'(1));
        check("stuck_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
        check("stuck_ready", 32'(tgt_ready), 32'(0));
        repeat (2) @(negedge clk);
        check("stuck_err_held", 32'(err), 32'(1));
        check("stuck_jk_low", 32'({j_out, k_out}), 32'(0));
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clear_err", 32'(err), 32'(0));
        check("clear_ready", 32'(tgt_ready), 32'(1));
        stuck0 = '0;

        // Reset in the middle of DRIVE.
        load_bank(8'h00);
        send(8'h55);
        check("mid_j", 32'(j_out), 32'(exp_jk(8'h00, 8'h55) >> W));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_j", 32'(j_out), 32'(0));
        check("mid_rst_k", 32'(k_out), 32'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(tgt_ready), 32'(1));
        check("mid_cnt", 32'(mismatch_cnt), 32'(0));
        exp_cnt = 0;
        send(8'hAA);
        check("mid_new_j", 32'(j_out), 32'(exp_jk(bank_q, 8'hAA) >> W));
        wait_done(n);
        check("mid_new_latency", 32'(n + 1), 32'(3));

        // Counter saturation: 85 error runs of 3 mismatches = 255.
        stuck0 = 8'h01;
        load_bank(8'h00);
        for (int r = 0; r < 86; r++) begin
            send(8'h01);
            wait_err(drives);
            exp_q.delete();
            exp_cnt = (exp_cnt + 3 > 255) ? 255 : exp_cnt + 3;
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
            if (r == 84) check("sat_reach", 32'(mismatch_cnt), 32'(exp_cnt));
        end
        check("sat_hold", 32'(mismatch_cnt), 32'(255));
        stuck0 = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
